// File: rtl/multicycle_main_cu.sv
// Multicycle MIPS main control unit.
// A Moore sequencer that walks each instruction through IF/ID/EX/MEM/WB and drives the
// datapath enables plus the ALU-control request lines. The only Mealy output is the
// jr redirect in EX_R, which uses the ALU controller's jr flag in the same cycle.
module multicycle_main_cu (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       jr,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic       IorD,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] pcSrc,
   output logic [1:0] regDst,
   output logic [1:0] memToReg,
   output logic       aluAdd,
   output logic       aluSub,
   output logic       aluAnd,
   output logic       aluOp,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpAndi = 6'b001100;
   localparam logic [5:0] OpJ    = 6'b000010;
   localparam logic [5:0] OpJal  = 6'b000011;

   localparam logic [3:0] StIf      = 4'd0;
   localparam logic [3:0] StId      = 4'd1;
   localparam logic [3:0] StMemAddr = 4'd2;
   localparam logic [3:0] StMemRd   = 4'd3;
   localparam logic [3:0] StWbLw    = 4'd4;
   localparam logic [3:0] StMemWr   = 4'd5;
   localparam logic [3:0] StExR     = 4'd6;
   localparam logic [3:0] StWbR     = 4'd7;
   localparam logic [3:0] StExBeq   = 4'd8;
   localparam logic [3:0] StExAddi  = 4'd9;
   localparam logic [3:0] StExAndi  = 4'd10;
   localparam logic [3:0] StWbI     = 4'd11;
   localparam logic [3:0] StJump    = 4'd12;
   localparam logic [3:0] StJal     = 4'd13;

   logic [3:0] state_q, state_d;

   // Branch-taken gating on zero lives in the datapath, so the flag is not used here.
   logic unused_zero;
   assign unused_zero = zero;

   assign state = state_q;

   // Next-state selection; unreachable codes fall back to IF.
   always_comb begin
      state_d = StIf;
      case (state_q)
         StIf: state_d = StId;
         StId: begin
            case (opcode)
               OpLw, OpSw: state_d = StMemAddr;
               OpR:        state_d = StExR;
               OpBeq:      state_d = StExBeq;
               OpAddi:     state_d = StExAddi;
               OpAndi:     state_d = StExAndi;
               OpJ:        state_d = StJump;
               OpJal:      state_d = StJal;
               default:    state_d = StIf;
            endcase
         end
         StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
         StMemRd:   state_d = StWbLw;
         StExR:     state_d = jr ? StIf : StWbR;
         StExAddi,
         StExAndi:  state_d = StWbI;
         default:   state_d = StIf;
      endcase
   end

   // State register with asynchronous abort back to IF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIf;
      end else begin
         state_q <= state_d;
      end
   end

   // Output decode; everything is forced low while reset is held.
   always_comb begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
      IorD        = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      pcSrc       = 2'b00;
      regDst      = 2'b00;
      memToReg    = 2'b00;
      aluAdd      = 1'b0;
      aluSub      = 1'b0;
      aluAnd      = 1'b0;
      aluOp       = 1'b0;
      illegal     = 1'b0;
      if (!rst) begin
         case (state_q)
            StIf: begin
               memRead = 1'b1;
               irWrite = 1'b1;
               aluSrcB = 2'b01;
               aluAdd  = 1'b1;
               pcWrite = 1'b1;
            end
            StId: begin
               // Branch target is precomputed into ALUOut here.
               aluSrcB = 2'b11;
               aluAdd  = 1'b1;
               case (opcode)
                  OpR, OpLw, OpSw, OpBeq, OpAddi, OpAndi, OpJ, OpJal: illegal = 1'b0;
                  default: illegal = 1'b1;
               endcase
            end
            StMemAddr: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluAdd  = 1'b1;
            end
            StMemRd: begin
               memRead = 1'b1;
               IorD    = 1'b1;
            end
            StWbLw: begin
               regWrite = 1'b1;
               memToReg = 2'b01;
            end
            StMemWr: begin
               memWrite = 1'b1;
               IorD     = 1'b1;
            end
            StExR: begin
               aluSrcA = 1'b1;
               aluOp   = 1'b1;
               if (jr) begin
                  pcWrite = 1'b1;
                  pcSrc   = 2'b11;
               end
            end
            StWbR: begin
               regWrite = 1'b1;
               regDst   = 2'b01;
            end
            StExBeq: begin
               aluSrcA     = 1'b1;
               aluSub      = 1'b1;
               pcWriteCond = 1'b1;
               pcSrc       = 2'b01;
            end
            StExAddi: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluAdd  = 1'b1;
            end
            StExAndi: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluAnd  = 1'b1;
            end
            StWbI: begin
               regWrite = 1'b1;
            end
            StJump: begin
               pcWrite = 1'b1;
               pcSrc   = 2'b10;
            end
            StJal: begin
               pcWrite  = 1'b1;
               pcSrc    = 2'b10;
               regWrite = 1'b1;
               regDst   = 2'b10;
               memToReg = 2'b10;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_main_cu.sv
// Self-checking bench for multicycle_main_cu: a per-instruction state-sequence model plus
// a per-state control table, compared every cycle, with directed and random instructions.
module tb_multicycle_main_cu;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       i_or_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_add;
      logic       alu_sub;
      logic       alu_and;
      logic       alu_op;
      logic       illegal;
   } ctrl_t;

   logic       clk, rst, zero, jr;
   logic [5:0] opcode;
   logic       pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, IorD, aluSrcA;
   logic [1:0] aluSrcB, pcSrc, regDst, memToReg;
   logic       aluAdd, aluSub, aluAnd, aluOp, illegal;
   logic [3:0] state;

   multicycle_main_cu dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .jr(jr),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite), .memRead(memRead),
      .memWrite(memWrite), .regWrite(regWrite), .IorD(IorD), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .pcSrc(pcSrc), .regDst(regDst), .memToReg(memToReg),
      .aluAdd(aluAdd), .aluSub(aluSub), .aluAnd(aluAnd), .aluOp(aluOp),
      .illegal(illegal), .state(state)
   );

   ctrl_t dut_ctrl;
   assign dut_ctrl = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, IorD,
                      aluSrcA, aluSrcB, pcSrc, regDst, memToReg,
                      aluAdd, aluSub, aluAnd, aluOp, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   bit    exp_valid = 1'b0;
   int    exp_state = 0;
   ctrl_t exp_ctrl  = '0;
   int    seq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                        6'b001000, 6'b001100, 6'b000010, 6'b000011};
   endfunction

   // Expected control word for a given step of the instruction flow.
   function automatic ctrl_t model_ctrl(input int st, input bit jr_v, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (st)
         0:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01;
                   c.alu_add = 1; c.pc_write = 1; end
         1:  begin c.alu_src_b = 2'b11; c.alu_add = 1; c.illegal = !is_legal(op); end
         2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_add = 1; end
         3:  begin c.mem_read = 1; c.i_or_d = 1; end
         4:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
         5:  begin c.mem_write = 1; c.i_or_d = 1; end
         6:  begin c.alu_src_a = 1; c.alu_op = 1;
                   if (jr_v) begin c.pc_write = 1; c.pc_src = 2'b11; end end
         7:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
         8:  begin c.alu_src_a = 1; c.alu_sub = 1; c.pc_write_cond = 1; c.pc_src = 2'b01; end
         9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_add = 1; end
         10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_and = 1; end
         11: begin c.reg_write = 1; end
         12: begin c.pc_write = 1; c.pc_src = 2'b10; end
         13: begin c.pc_write = 1; c.pc_src = 2'b10; c.reg_write = 1;
                   c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Visited-state list for one instruction.
   task automatic build_seq(input logic [5:0] op, input bit jr_sel);
      seq = {0, 1};
      case (op)
         6'b100011: seq = {seq, 2, 3, 4};
         6'b101011: seq = {seq, 2, 5};
         6'b000000: seq = jr_sel ? {seq, 6} : {seq, 6, 7};
         6'b000100: seq = {seq, 8};
         6'b001000: seq = {seq, 9, 11};
         6'b001100: seq = {seq, 10, 11};
         6'b000010: seq = {seq, 12};
         6'b000011: seq = {seq, 13};
         default: ;
      endcase
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (exp_valid) begin
         chk("state", 32'(state), 32'(exp_state));
         chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
         chk("alu_onehot", 32'($countones({aluAdd, aluSub, aluAnd, aluOp}) <= 1), 32'd1);
      end
   end

   // Runs one instruction starting at posedge+1 of its IF cycle.
   task automatic run_instr(input logic [5:0] op, input bit jr_sel, input bit rst_mid);
      build_seq(op, jr_sel);
      for (int k = 0; k < seq.size(); k++) begin
         opcode    = op;
         zero      = 1'($urandom);
         jr        = (seq[k] == 6) ? jr_sel : 1'($urandom);
         exp_state = seq[k];
         exp_ctrl  = model_ctrl(seq[k], jr, op);
         #1;
         // Hand-computed pins independent of the model table.
         case (seq[k])
            0: chk("if_enables", 32'({memRead, irWrite, pcWrite, aluAdd}), 32'hF);
            1: chk("id_illegal", 32'(illegal), 32'(op == 6'b111111 ? 1 : (is_legal(op) ? 0 : 1)));
            3: chk("lw_memrd", 32'({memRead, IorD, regWrite}), 32'b110);
            6: if (jr_sel) chk("jr_redirect", 32'({pcWrite, pcSrc, regWrite}), 32'b1110);
            8: chk("beq_ctrl", 32'({aluSub, pcWriteCond, pcSrc}), 32'b1101);
            13: chk("jal_ctrl", 32'({regDst, memToReg, pcSrc}), 32'b101010);
            default: ;
         endcase
         if (rst_mid && seq[k] == 3) begin
            @(negedge clk);
            #2;
            rst       = 1'b1;
            exp_state = 0;
            exp_ctrl  = '0;
            #1;
            chk("rst_abort_state", 32'(state), 32'd0);
            chk("rst_abort_ctrl", 32'(dut_ctrl), 32'd0);
            @(posedge clk);
            #1;
            chk("rst_hold_ctrl", 32'({state, dut_ctrl}), 32'd0);
            rst = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] legal_ops [8];
      logic [5:0] op;
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                    6'b001000, 6'b001100, 6'b000010, 6'b000011};
      rst    = 1'b1;
      opcode = 6'b100011;
      jr     = 1'b1;
      zero   = 1'b1;
      exp_valid = 1'b1;
      exp_state = 0;
      exp_ctrl  = '0;
      #1;
      chk("reset_ctrl", 32'(dut_ctrl), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed scenarios.
      run_instr(6'b100011, 1'b0, 1'b0);  // LW
      run_instr(6'b100011, 1'b0, 1'b1);  // LW aborted by reset in MEM_RD
      run_instr(6'b000000, 1'b0, 1'b0);  // ADD
      run_instr(6'b000000, 1'b1, 1'b0);  // JR
      run_instr(6'b000100, 1'b0, 1'b0);  // BEQ
      run_instr(6'b101011, 1'b0, 1'b0);  // SW
      run_instr(6'b000011, 1'b0, 1'b0);  // JAL
      run_instr(6'b001100, 1'b0, 1'b0);  // ANDI
      run_instr(6'b001000, 1'b0, 1'b0);  // ADDI
      run_instr(6'b000010, 1'b0, 1'b0);  // J
      run_instr(6'b111111, 1'b0, 1'b0);  // illegal

      // Random instruction stream.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(3) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(7)];
         run_instr(op, 1'($urandom), 1'b0);
      end

      exp_valid = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_main_cu.md
# multicycle_main_cu

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and the ALU-control request lines `aluAdd`, `aluSub`, `aluAnd` and `aluOp`, which feed the ALU controller. It also consumes the ALU controller's `jr` flag back from it. It sits beside the ALU controller in the multicycle top level, replacing the single-cycle combinational decoder.

## Interface
- No parameters. Opcodes are fixed: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, ANDI=001100, J=000010, JAL=000011.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset; one clock, `clk`.
- `opcode`  in  6  IR[31:26]; valid from ID onward.
- `zero`  in  1  ALU zero flag.
- `jr`  in  1  from the ALU controller; meaningful only while `aluOp`=1.
- `pcWrite`, `pcWriteCond`, `irWrite`, `memRead`, `memWrite`, `regWrite`  out  1 each  datapath enables.
- `IorD`, `aluSrcA`  out  1 each  memory address select (0=PC, 1=ALUOut) / ALU A select (0=PC, 1=regA).
- `aluSrcB`  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pcSrc`  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=regA (jr).
- `regDst`  out  2  00=rt, 01=rd, 10=$31.
- `memToReg`  out  2  00=ALUOut, 01=MDR, 10=PC.
- `aluAdd`, `aluSub`, `aluAnd`, `aluOp`  out  1 each  ALU-control requests.
- `illegal`  out  1  one-cycle pulse in ID on an unknown opcode.
- `state`  out  4  current state, for debug.

## Operation
- State encoding: IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, WB_LW=4, MEM_WR=5, EX_R=6, WB_R=7, EX_BEQ=8, EX_ADDI=9, EX_ANDI=10, WB_I=11, JUMP=12, JAL=13. Codes 14-15 are unreachable and return to IF.
- Every output not listed for a state is 0.
- IF: memRead, irWrite, aluSrcB=01, aluAdd, pcWrite. → ID.
- ID: aluSrcB=11, aluAdd (branch target into ALUOut). Next state by opcode: LW/SW→MEM_ADDR, R→EX_R, BEQ→EX_BEQ, ADDI→EX_ADDI, ANDI→EX_ANDI, J→JUMP, JAL→JAL. Any other opcode→IF with `illegal`=1 for that cycle.
- MEM_ADDR: aluSrcA, aluSrcB=10, aluAdd. → MEM_RD for LW, MEM_WR for SW.
- MEM_RD: memRead, IorD. → WB_LW.
- WB_LW: regWrite, memToReg=01, regDst=00. → IF.
- MEM_WR: memWrite, IorD. → IF.
- EX_R: aluSrcA, aluSrcB=00, aluOp.
  - If `jr`=1: pcWrite=1 and pcSrc=11 in this same cycle (the only Mealy output), → IF.
  - Otherwise → WB_R.
- WB_R: regWrite, regDst=01, memToReg=00. → IF.
- EX_BEQ: aluSrcA, aluSrcB=00, aluSub, pcWriteCond, pcSrc=01. The PC is updated only if `zero`=1; that gating happens in the datapath. → IF.
- EX_ADDI: aluSrcA, aluSrcB=10, aluAdd. EX_ANDI: same, with aluAnd instead of aluAdd. Both → WB_I.
- WB_I: regWrite, regDst=00, memToReg=00. → IF.
- JUMP: pcWrite, pcSrc=10. → IF.
- JAL: pcWrite, pcSrc=10, regWrite, regDst=10, memToReg=10. → IF.
- Invariant: at most one of aluAdd/aluSub/aluAnd/aluOp is high in any cycle.

## Timing
- Reset: while `rst`=1, state=IF and every output is forced to 0, including the IF enables. The first rising edge after `rst` falls is treated as the IF cycle.
- Reset asserted mid-instruction aborts immediately (asynchronous). No write enable remains high after `rst` rises.
- Cycles per instruction, counting from IF:
  - 3 cycles: BEQ, J, JAL, jr
  - 4 cycles: R-type, SW, ADDI, ANDI
  - 5 cycles: LW
  - 2 cycles: illegal opcode
- `opcode` is sampled only in ID and MEM_ADDR; the IR is stable from the end of IF.
- `jr` and `zero` are combinational inputs, sampled in the same cycle they are used.

## Test plan
- Reset mid-LW: assert `rst` while in MEM_RD → state=0 and all outputs 0 within the same cycle. Release `rst` → IF enables (memRead, irWrite, pcWrite, aluAdd) high on the next cycle.
- LW, opcode 100011: states 0→1→2→3→4→0. aluAdd=1 in states 0, 1 and 2; memRead with IorD=1 in state 3; regWrite with memToReg=01 in state 4.
- R-type ADD then JR:
  - ADD: states 0→1→6→7→0, aluOp=1 only in state 6, regDst=01 in state 7.
  - JR (`jr`=1 in state 6): pcWrite=1 and pcSrc=11 in state 6, next state 0, regWrite never asserted.
- BEQ, opcode 000100: in state 8, aluSub=1, pcWriteCond=1, pcSrc=01. Outputs are the same with `zero`=0 and with `zero`=1; 3 cycles total.
- JAL then ANDI:
  - JAL: state 13 drives regDst=10, memToReg=10, pcSrc=10.
  - ANDI: states 0→1→10→11→0, aluAnd=1 only in state 10.
- Opcode 111111: `illegal` pulses for 1 cycle in state 1, next state 0, no write enable asserted. Across all scenarios, assert that the ALU request lines are one-hot-or-zero every cycle.
